// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider math, mid-bit index.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Oversample ticks per bit used when no override is given, and its sample index.
    localparam int OVERSAMPLE_DEF = 16;
    localparam int MID_IDX_DEF    = OVERSAMPLE_DEF / 2 - 1;

    // Clock cycles per oversample tick; integer division, truncating.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

    // Tick index inside a bit at which the line is sampled (centre of the bit).
    function automatic int mid_idx(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running clock divider emitting a one-cycle tick every DIV enabled cycles.
// Latency: first tick DIV enabled cycles after a clear; tick is combinational from the count.
// Backpressure: none; counting pauses while i_en is low, i_clr restarts the period.
module uart_tick_gen #(
    parameter int DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    import uart_pkg::*;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign o_tick = i_en && !i_clr && w_wrap;

    // Period counter: restart on clear, advance only while enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: start validation, LSB-first shift, stop check, 1-entry output buffer. Optional parity: UART_RX_PARITY_EN.
// Latency: word valid the cycle after the last stop-bit mid sample; frame_err/overrun/parity_err pulse in that same cycle.
// Backpressure: rx_valid holds until rx_ready; a word completing while the buffer is still full is dropped with an overrun pulse.
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int STOP_BITS   = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD  = 0
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [3:0]            bit_count
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int MID = mid_idx(OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx_sipo: CLK_FREQ_HZ too low for BAUD*OVERSAMPLE");
        end
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("uart_rx_sipo: DATA_WIDTH must be 5..9");
        end
    endgenerate

    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rx_s;
    logic                  w_tick;
    logic                  w_mid;
    logic [OSW-1:0]        r_os_cnt;
    logic [3:0]            r_bit_cnt;
    logic                  r_stop_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_armed;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_ovr;
    logic                  r_ferr;
    logic                  w_enter_start;
    logic                  w_start_ok;
    logic                  w_shift_en;
    logic                  w_stop_next;
    logic                  w_commit;
    logic                  w_ferr;
`ifdef UART_RX_PARITY_EN
    logic                  w_par_en;
    logic                  r_par_bad;
    logic                  r_perr;
`endif

    assign w_rx_s    = r_sync2;
    assign busy      = (r_state != ST_IDLE);
    assign w_mid     = w_tick && (r_os_cnt == OSW'(MID));
    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign overrun   = r_ovr;
    assign frame_err = r_ferr;
    assign bit_count = r_bit_cnt;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

    // Two-flop synchroniser for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    uart_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (busy),
        .i_clr   (w_enter_start),
        .o_tick  (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        w_state_nxt   = r_state;
        w_enter_start = 1'b0;
        w_start_ok    = 1'b0;
        w_shift_en    = 1'b0;
        w_stop_next   = 1'b0;
        w_commit      = 1'b0;
        w_ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // r_armed blocks re-triggering on a line still held low after a break.
                if (!w_rx_s && r_armed) begin
                    w_state_nxt   = ST_START;
                    w_enter_start = 1'b1;
                end
            end
            ST_START: begin
                if (w_mid) begin
                    if (w_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_start_ok  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_mid) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 4'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_mid) begin
                    w_par_en    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_mid) begin
                    if (!w_rx_s) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        // Leave at the sample, not the bit end, so a following start edge is seen.
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit-timing counters, shift register and break re-arm flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_armed    <= 1'b1;
        end else begin
            if (w_enter_start) begin
                r_os_cnt <= '0;
            end else if (w_tick) begin
                r_os_cnt <= (r_os_cnt == OSW'(OVERSAMPLE - 1)) ? '0 : r_os_cnt + 1'b1;
            end
            if (w_enter_start || w_start_ok) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_start_ok) begin
                r_stop_cnt <= 1'b0;
            end else if (w_stop_next) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            end
            if (w_ferr) begin
                r_armed <= 1'b0;
            end else if (r_state == ST_IDLE && w_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict captured at the parity-bit sample, reported at commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_bad <= 1'b0;
        end else if (w_par_en) begin
            r_par_bad <= (^r_shift) ^ w_rx_s ^ 1'(PARITY_ODD);
        end
    end
`endif

    // One-entry output buffer with overrun and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;
            if (w_commit) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            r_perr <= w_commit && r_par_bad;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_sipo.sv
module tb_uart_rx_sipo;
    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic [3:0] bit_count;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int cnt_ferr = 0, cnt_ovr = 0, cnt_perr = 0;
    int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    int cyc = 0;
    int last_rise = 0;
    int stop_begin = 0;
    logic       prev_valid = 1'b0;
    logic       prev_xfer = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx_sipo #(
        .DATA_WIDTH  (8),
        .CLK_FREQ_HZ (1_600_000),
        .BAUD        (100_000),
        .OVERSAMPLE  (16),
        .STOP_BITS   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .bit_count (bit_count)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and watches the pulse outputs.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (rx_valid && !prev_valid) last_rise = cyc;
            if (rx_valid && prev_valid && !prev_xfer)
                check("rx_data held while valid", int'(rx_data), int'(prev_data));
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check("unexpected word", int'(rx_data), -1);
                else check("rx_data", int'(rx_data), exp_q.pop_front());
            end
            if (frame_err) cnt_ferr++;
            if (overrun) cnt_ovr++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) cnt_perr++;
`endif
            prev_valid = rx_valid;
            prev_xfer  = rx_valid && rx_ready;
            prev_data  = rx_data;
        end else begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialise one frame: start, data LSB first, optional parity, one stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip,
                              input logic expect_word);
        logic pbit;
        pbit = (^d) ^ par_flip;
        if (expect_word) exp_q.push_back(int'(d));
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        drive(pbit, BIT);
`endif
        stop_begin = cyc;
        drive(stop_v, BIT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       bad;
        int         lat;
        int         n;
        reset = 1'b0;
        rx = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset rx_valid", int'(rx_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset rx_data", int'(rx_data), 0);
        check("reset bit_count", int'(bit_count), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset overrun", int'(overrun), 0);
        reset = 1'b1;
        drive(1'b1, 8);

        // Clean frame with latency window relative to the stop bit.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4);
        lat = last_rise - stop_begin;
        check("valid inside stop bit", int'(lat >= 8 && lat <= 14), 1);
        check("A5 consumed", exp_q.size(), 0);
        check("A5 frame_err count", cnt_ferr, exp_ferr);

        // Short low glitch is not a start bit.
        drive(1'b0, 4);
        drive(1'b1, 30);
        check("glitch busy", int'(busy), 0);
        check("glitch frame_err count", cnt_ferr, exp_ferr);
        check("glitch no word", int'(rx_valid), 0);

        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        exp_ferr++;
        drive(1'b1, 20);
        check("bad stop frame_err count", cnt_ferr, exp_ferr);
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4);
        check("11 consumed", exp_q.size(), 0);

        // Break: one framing error, no re-trigger while the line stays low.
        drive(1'b0, BIT * 20);
        exp_ferr++;
        check("break busy low", int'(busy), 0);
        check("break frame_err count", cnt_ferr, exp_ferr);
        drive(1'b1, 20);
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4);
        check("55 after break", exp_q.size(), 0);

        // Overrun: second word dropped, first kept.
        rx_ready = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        send_frame(8'h02, 1'b1, 1'b0, 1'b0);
        exp_ovr++;
        drive(1'b1, 8);
        check("overrun count", cnt_ovr, exp_ovr);
        check("overrun valid held", int'(rx_valid), 1);
        check("overrun keeps first", int'(rx_data), 8'h01);
        rx_ready = 1'b1;
        drive(1'b1, 4);
        check("overrun drained", exp_q.size(), 0);

        // Consumer accepts exactly in the commit cycle: both words delivered.
        rx_ready = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4);
        fork
            send_frame(8'h02, 1'b1, 1'b0, 1'b1);
            begin : raiser
                int k;
                k = 0;
                while (!busy && k < 400) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                check("busy rise seen", int'(busy), 1);
                // Final stop sample is tick 9*16+7 after start entry.
                repeat (151) @(posedge clk);
                #1;
                rx_ready = 1'b1;
            end
        join
        drive(1'b1, 4);
        check("commit-cycle ready no overrun", cnt_ovr, exp_ovr);
        check("commit-cycle ready drained", exp_q.size(), 0);
        check("commit-cycle ready data", int'(rx_data), 8'h02);

        // Reset in the middle of the data bits.
        drive(1'b0, BIT);
        drive(1'b1, BIT);
        drive(1'b0, 8);
        reset = 1'b0;
        #1;
        check("midreset rx_valid", int'(rx_valid), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset rx_data", int'(rx_data), 0);
        check("midreset bit_count", int'(bit_count), 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, 20);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4);
        check("7E after reset", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1.
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        exp_perr++;
        drive(1'b1, 4);
        check("parity bad count", cnt_perr, exp_perr);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4);
        check("parity good count", cnt_perr, exp_perr);
`endif

        // Random traffic, occasional framing errors, random idle gaps.
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            send_frame(d, !bad, 1'b0, !bad);
            if (bad) begin
                exp_ferr++;
                drive(1'b1, 20);
            end else begin
                drive(1'b1, $urandom_range(0, 12));
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        drive(1'b1, 20);
        check("final queue drained", exp_q.size(), 0);
        check("final frame_err count", cnt_ferr, exp_ferr);
        check("final overrun count", cnt_ovr, exp_ovr);
        check("final parity_err count", cnt_perr, exp_perr);
        check("final idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
Parametrised UART receive path, the successor to the fixed 8-bit SIPO receiver. It oversamples a serial line, detects and validates the start bit, and shifts DATA_WIDTH bits LSB-first. It then checks the stop bit(s) and presents the word through a one-entry valid/ready output buffer. It sits between the pad-side rx line and the byte-level consumer (FIFO or command decoder).

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
CLK_FREQ_HZ, 50_000_000, clk frequency
BAUD, 115200, line rate
OVERSAMPLE, 16, ticks per bit (even, >=4)
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_WIDTH  received word, stable while rx_valid
rx_valid  output  1  word available
rx_ready  input  1  consumer accepts word (transfer on valid && ready at posedge)
busy  output  1  frame in progress (state != IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed word dropped because buffer full
bit_count  output  4  data bits captured in current frame (debug)

Behaviour:
- Reset (reset low, async): state IDLE, tick counter and bit_count 0, shift reg 0, rx_data 0, rx_valid 0, busy 0, frame_err 0, overrun 0, sync flops 1.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Tick: DIV = CLK_FREQ_HZ/(BAUD*OVERSAMPLE), integer, must be >=1 (elaboration error otherwise). Divider free-runs only when busy, and is cleared on entry to START.
- Sample point: tick index OVERSAMPLE/2-1 of each bit (mid-bit).
- FSM:
  IDLE: on synchronised rx = 0 -> START.
  START: at mid-bit, if rx = 1 -> IDLE (glitch, no flag); else -> DATA, bit_count 0.
  DATA: at each mid-bit, shift rx in at MSB (LSB-first line order), bit_count++. After DATA_WIDTH bits -> PARITY if macro defined, else STOP.
  PARITY (macro only): one bit time, compare sample, -> STOP.
  STOP: sample each of STOP_BITS at mid-bit. Any 0 -> frame_err pulse, word discarded, -> IDLE. All 1 -> commit, -> IDLE immediately after the last stop sample (no wait for bit end, so back-to-back frames are caught).
- Commit, in the cycle after the final stop sample:
  - If !rx_valid, or rx_valid && rx_ready in the same cycle: rx_data <= shift reg, rx_valid <= 1.
  - Else: overrun pulses 1 cycle; old word kept; new word dropped.
- rx_valid clears on a valid && ready cycle without a simultaneous commit.
- rx_data holds its value while rx_valid = 1.
- A frame_err frame never sets rx_valid and never raises overrun.
- Line held low (break): frame_err once, then wait in IDLE for rx = 1 before a new start is armed.

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds parameter PARITY_ODD (default 0 = even), PARITY state, and output parity_err. parity_err is a 1-cycle pulse aligned with commit; the word is still committed and rx_valid still asserts.
- Undefined: no parity bit is expected on the line, and the parity_err port does not exist.

Decomposition:
- uart_pkg: rx state enum (IDLE, START, DATA, PARITY, STOP), function computing DIV, localparam for the mid-bit index.
- Sub-module uart_tick_gen: parametrised divider producing an oversample tick with a synchronous clear. It is reusable by the future TX block.

Test Plan:
Bench params CLK_FREQ_HZ=1_600_000, BAUD=100_000, OVERSAMPLE=16 (1 bit = 16 clk).
- Send 0xA5 (8N1), rx_ready=1 -> rx_valid for exactly 1 cycle with rx_data=0xA5, 1 cycle after the stop mid-sample; frame_err=0.
- rx low pulse for 4 clk -> returns to IDLE, busy drops, no rx_valid, no frame_err.
- Send 0x3C with the stop bit driven 0 -> frame_err pulse, no rx_valid; then send 0x11 -> rx_valid with 0x11.
- rx_ready=0, send 0x01 then 0x02 back-to-back -> rx_valid held with 0x01, overrun pulse at the second commit. Repeat with rx_ready rising in the commit cycle -> rx_data=0x02, no overrun.
- Assert reset low in the middle of the DATA bits -> all outputs at reset values immediately; next full frame 0x7E is received correctly.
- UART_RX_PARITY_EN, even parity: send 0x07 with parity bit 0 -> rx_data=0x07 with a parity_err pulse; send it with parity bit 1 -> no parity_err.
